// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the hazard control unit.
// Holds the register-address width, the hazard controller state encoding,
// and the encoding of register $zero, which is never a true dependency.
package mips_pipe_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [4:0]  REG_ZERO   = 5'd0;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      STALL  = 2'b01,
      HALTED = 2'b10
   } hcu_state_e;

endpackage

// File: rtl/hcu_hazard_detect.sv
// Combinational hazard detector for the ID stage.
// Returns the number of stall cycles the ID instruction requires (0..2).
// Ports:
//   i_id_rs, i_id_rt    source registers of the ID instruction
//   i_id_uses_rt        ID instruction reads rt
//   i_id_branch         ID instruction compares operands in ID (beq/bne)
//   i_exe_mem_read      EX instruction is a load
//   i_exe_reg_write     EX instruction writes a register
//   i_exe_reg_dst       EX destination register
//   i_mem_mem_read      MEM instruction is a load
//   i_mem_reg_dst       MEM destination register
//   o_n                 required stall cycles
module hcu_hazard_detect
   import mips_pipe_pkg::*;
#(
   parameter int unsigned ADDR_W = mips_pipe_pkg::REG_ADDR_W
) (
   input  logic [ADDR_W-1:0] i_id_rs,
   input  logic [ADDR_W-1:0] i_id_rt,
   input  logic              i_id_uses_rt,
   input  logic              i_id_branch,
   input  logic              i_exe_mem_read,
   input  logic              i_exe_reg_write,
   input  logic [ADDR_W-1:0] i_exe_reg_dst,
   input  logic              i_mem_mem_read,
   input  logic [ADDR_W-1:0] i_mem_reg_dst,
   output logic [1:0]        o_n
);

   logic w_match_exe;
   logic w_match_mem;

   assign w_match_exe = (i_exe_reg_dst != ADDR_W'(REG_ZERO)) &&
                        ((i_exe_reg_dst == i_id_rs) ||
                         (i_id_uses_rt && (i_exe_reg_dst == i_id_rt)));
   assign w_match_mem = (i_mem_reg_dst != ADDR_W'(REG_ZERO)) &&
                        ((i_mem_reg_dst == i_id_rs) ||
                         (i_id_uses_rt && (i_mem_reg_dst == i_id_rt)));

   // Later assignments only ever raise the count, so the largest value wins.
   always_comb begin
      o_n = '0;
      if (i_id_branch && i_mem_mem_read && w_match_mem)
         o_n = 2'd1;
      if (i_id_branch && i_exe_reg_write && !i_exe_mem_read && w_match_exe)
         o_n = 2'd1;
      if (i_exe_mem_read && w_match_exe)
         o_n = i_id_branch ? 2'd2 : 2'd1;
   end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control unit with debug run/stall/halt control.
// Optional feature macro: HCU_STALL_COUNTER_EN (saturating stall-cycle counter;
// when undefined, O_HCU_StallCount is tied to zero).
// Ports:
//   CLK, RESET              clock, synchronous active-low reset
//   I_HCU_ID_*              ID instruction operands / branch info
//   I_HCU_EXE_*, I_HCU_MEM_* downstream destination and load info
//   I_HCU_Halt, I_HCU_Step  debug halt level and single-step pulse
//   O_HCU_PCWrite, O_HCU_IFID_Write, O_HCU_IFID_Flush,
//   O_HCU_IDEX_Bubble, O_HCU_PipeEnable   pipeline control
//   O_HCU_StallCount        bubble cycles since reset
module hazard_control_unit
   import mips_pipe_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [REG_ADDR_W-1:0] I_HCU_ID_RS,
   input  logic [REG_ADDR_W-1:0] I_HCU_ID_RT,
   input  logic                  I_HCU_ID_UsesRT,
   input  logic                  I_HCU_ID_Branch,
   input  logic                  I_HCU_ID_BranchTaken,
   input  logic                  I_HCU_EXE_MemRead,
   input  logic                  I_HCU_EXE_RegWrite,
   input  logic [REG_ADDR_W-1:0] I_HCU_EXE_regDst,
   input  logic                  I_HCU_MEM_MemRead,
   input  logic [REG_ADDR_W-1:0] I_HCU_MEM_regDst,
   input  logic                  I_HCU_Halt,
   input  logic                  I_HCU_Step,
   output logic                  O_HCU_PCWrite,
   output logic                  O_HCU_IFID_Write,
   output logic                  O_HCU_IFID_Flush,
   output logic                  O_HCU_IDEX_Bubble,
   output logic                  O_HCU_PipeEnable,
   output logic [CNT_WIDTH-1:0]  O_HCU_StallCount
);

   hcu_state_e r_state;
   hcu_state_e w_state_next;
   logic [1:0] r_remaining;
   logic [1:0] w_remaining_next;
   logic [1:0] w_n;

   hcu_hazard_detect #(.ADDR_W(REG_ADDR_W)) u_detect (
      .i_id_rs         (I_HCU_ID_RS),
      .i_id_rt         (I_HCU_ID_RT),
      .i_id_uses_rt    (I_HCU_ID_UsesRT),
      .i_id_branch     (I_HCU_ID_Branch),
      .i_exe_mem_read  (I_HCU_EXE_MemRead),
      .i_exe_reg_write (I_HCU_EXE_RegWrite),
      .i_exe_reg_dst   (I_HCU_EXE_regDst),
      .i_mem_mem_read  (I_HCU_MEM_MemRead),
      .i_mem_reg_dst   (I_HCU_MEM_regDst),
      .o_n             (w_n)
   );

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state     <= RUN;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_next;
         r_remaining <= w_remaining_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_remaining_next  = r_remaining;
      O_HCU_PCWrite     = 1'b0;
      O_HCU_IFID_Write  = 1'b0;
      O_HCU_IFID_Flush  = 1'b0;
      O_HCU_IDEX_Bubble = 1'b0;
      O_HCU_PipeEnable  = 1'b0;
      if (!RESET) begin
         O_HCU_IFID_Flush  = 1'b1;
         O_HCU_IDEX_Bubble = 1'b1;
         w_state_next      = RUN;
         w_remaining_next  = '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_n != 2'd0) begin
                  O_HCU_IDEX_Bubble = 1'b1;
                  O_HCU_PipeEnable  = 1'b1;
                  if (w_n == 2'd2) begin
                     w_state_next     = STALL;
                     w_remaining_next = 2'd1;
                  end
               end else begin
                  O_HCU_PCWrite    = 1'b1;
                  O_HCU_IFID_Write = 1'b1;
                  O_HCU_PipeEnable = 1'b1;
                  O_HCU_IFID_Flush = I_HCU_ID_BranchTaken;
                  if (I_HCU_Halt)
                     w_state_next = HALTED;
               end
            end
            STALL: begin
               // Branch operands are stale here, so a taken resolution is ignored.
               O_HCU_IDEX_Bubble = 1'b1;
               O_HCU_PipeEnable  = 1'b1;
               if (r_remaining <= 2'd1) begin
                  w_remaining_next = '0;
                  w_state_next     = RUN;
               end else begin
                  w_remaining_next = r_remaining - 2'd1;
               end
            end
            HALTED: begin
               // A step with a pending hazard issues one stall; the next step
               // re-evaluates, so a 2-cycle hazard takes two steps.
               if (I_HCU_Step) begin
                  O_HCU_PipeEnable = 1'b1;
                  if (w_n != 2'd0) begin
                     O_HCU_IDEX_Bubble = 1'b1;
                  end else begin
                     O_HCU_PCWrite    = 1'b1;
                     O_HCU_IFID_Write = 1'b1;
                     O_HCU_IFID_Flush = I_HCU_ID_BranchTaken;
                  end
               end
               if (!I_HCU_Halt)
                  w_state_next = RUN;
            end
            default: begin
               w_state_next     = RUN;
               w_remaining_next = '0;
            end
         endcase
      end
   end

`ifdef HCU_STALL_COUNTER_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   always_ff @(posedge CLK) begin
      if (!RESET)
         r_stall_cnt <= '0;
      else if (O_HCU_IDEX_Bubble && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
   end

   assign O_HCU_StallCount = r_stall_cnt;
`else
   assign O_HCU_StallCount = '0;
`endif

endmodule
